// File: rtl/audio_mem_arbiter_if.sv
// rtl/audio_mem_arbiter_if.sv - requester, read-return and RAM port bundle for audio_mem_arbiter
interface audio_mem_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 16
);
    logic              Rec_Req;
    logic [ADDR_W-1:0] Rec_Addr;
    logic [DATA_W-1:0] Rec_Wdata;
    logic              Rec_Gnt;

    logic              Ply_Req;
    logic [ADDR_W-1:0] Ply_Addr;
    logic              Ply_Gnt;
    logic              Ply_Rvalid;

    logic              Shf_Req;
    logic              Shf_We;
    logic [ADDR_W-1:0] Shf_Addr;
    logic [DATA_W-1:0] Shf_Wdata;
    logic              Shf_Gnt;
    logic              Shf_Rvalid;

    logic [DATA_W-1:0] Rd_Data;

    logic              Mem_En;
    logic              Mem_We;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [DATA_W-1:0] Mem_Wdata;
    logic [DATA_W-1:0] Mem_Rdata;

    logic              Busy;

    // Requesters and the RAM model
    modport master (
        output Rec_Req, Rec_Addr, Rec_Wdata,
        output Ply_Req, Ply_Addr,
        output Shf_Req, Shf_We, Shf_Addr, Shf_Wdata,
        output Mem_Rdata,
        input  Rec_Gnt, Ply_Gnt, Ply_Rvalid, Shf_Gnt, Shf_Rvalid, Rd_Data,
        input  Mem_En, Mem_We, Mem_Addr, Mem_Wdata, Busy
    );

    // Arbiter
    modport slave (
        input  Rec_Req, Rec_Addr, Rec_Wdata,
        input  Ply_Req, Ply_Addr,
        input  Shf_Req, Shf_We, Shf_Addr, Shf_Wdata,
        input  Mem_Rdata,
        output Rec_Gnt, Ply_Gnt, Ply_Rvalid, Shf_Gnt, Shf_Rvalid, Rd_Data,
        output Mem_En, Mem_We, Mem_Addr, Mem_Wdata, Busy
    );
endinterface

// File: rtl/audio_mem_arbiter.sv
// rtl/audio_mem_arbiter.sv - three-way single-port sample RAM arbiter (option macro: ARB_ROUND_ROBIN_EN)
module audio_mem_arbiter #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    audio_mem_arbiter_if.slave bus
);

    // Owner of a read travelling through the pipeline; NONE also marks writes and empty slots
    typedef enum logic [1:0] {
        TAG_NONE = 2'b00,
        TAG_PLY  = 2'b01,
        TAG_SHF  = 2'b10
    } tag_t;

    logic rec_gnt;
    logic ply_gnt;
    logic shf_gnt;
    logic ply_first;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_ply_q;

    // Pointer flips after every player or shifter grant so the two alternate under contention
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rr_ply_q <= 1'b1;
        end else if (ply_gnt || shf_gnt) begin
            rr_ply_q <= ~rr_ply_q;
        end
    end

    assign ply_first = rr_ply_q;
`else
    assign ply_first = 1'b1;
`endif

    // Combinational grants: recorder always wins, then player/shifter by ply_first
    always_comb begin
        rec_gnt = Reset && bus.Rec_Req;
        ply_gnt = Reset && !bus.Rec_Req && bus.Ply_Req && (ply_first || !bus.Shf_Req);
        shf_gnt = Reset && !bus.Rec_Req && bus.Shf_Req && !(bus.Ply_Req && ply_first);
    end

    assign bus.Rec_Gnt = rec_gnt;
    assign bus.Ply_Gnt = ply_gnt;
    assign bus.Shf_Gnt = shf_gnt;

    tag_t s1_tag_d;

    // Tag only reads; recorder and shifter writes never return data
    always_comb begin
        s1_tag_d = TAG_NONE;
        if (ply_gnt) begin
            s1_tag_d = TAG_PLY;
        end else if (shf_gnt && !bus.Shf_We) begin
            s1_tag_d = TAG_SHF;
        end
    end

    logic              s1_valid;
    logic              s1_we;
    tag_t              s1_tag;
    logic [ADDR_W-1:0] s1_addr;
    logic [DATA_W-1:0] s1_wdata;

    // Stage 1: register the granted request; this is what drives the RAM port
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            s1_valid <= 1'b0;
            s1_we    <= 1'b0;
            s1_tag   <= TAG_NONE;
            s1_addr  <= '0;
            s1_wdata <= '0;
        end else begin
            s1_valid <= rec_gnt || ply_gnt || shf_gnt;
            s1_we    <= rec_gnt || (shf_gnt && bus.Shf_We);
            s1_tag   <= s1_tag_d;
            if (rec_gnt) begin
                s1_addr  <= bus.Rec_Addr;
                s1_wdata <= bus.Rec_Wdata;
            end else if (ply_gnt) begin
                s1_addr  <= bus.Ply_Addr;
            end else if (shf_gnt) begin
                s1_addr  <= bus.Shf_Addr;
                s1_wdata <= bus.Shf_Wdata;
            end
        end
    end

    assign bus.Mem_En    = s1_valid;
    assign bus.Mem_We    = s1_we;
    assign bus.Mem_Addr  = s1_addr;
    assign bus.Mem_Wdata = s1_wdata;

    tag_t              s2_tag;
    logic [DATA_W-1:0] rd_hold;

    // Stage 2: the RAM answers in this cycle; capture it so Rd_Data holds between reads
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            s2_tag  <= TAG_NONE;
            rd_hold <= '0;
        end else begin
            s2_tag <= s1_tag;
            if (s2_tag != TAG_NONE) begin
                rd_hold <= bus.Mem_Rdata;
            end
        end
    end

    // RAM data is forwarded in the Rvalid cycle to keep grant-to-Rvalid at two cycles
    assign bus.Rd_Data    = (s2_tag != TAG_NONE) ? bus.Mem_Rdata : rd_hold;
    assign bus.Ply_Rvalid = (s2_tag == TAG_PLY);
    assign bus.Shf_Rvalid = (s2_tag == TAG_SHF);
    assign bus.Busy       = s1_valid || (s2_tag != TAG_NONE);

endmodule

// File: tb/tb_audio_mem_arbiter.sv
// tb/tb_audio_mem_arbiter.sv - randomized and directed self-checking bench for audio_mem_arbiter
module tb_audio_mem_arbiter;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 16;
    localparam int MEM_SZ = 1 << ADDR_W;
    localparam int W_NONE = 0;
    localparam int W_REC  = 1;
    localparam int W_PLY  = 2;
    localparam int W_SHF  = 3;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    always #5 Clk = ~Clk;

    audio_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    audio_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    // Synchronous single-port RAM attached to the arbiter
    logic [DATA_W-1:0] ram [0:MEM_SZ-1];
    logic [DATA_W-1:0] ram_q = '0;

    always @(posedge Clk) begin
        if (bus.Mem_En) begin
            if (bus.Mem_We) ram[bus.Mem_Addr] <= bus.Mem_Wdata;
            else            ram_q <= ram[bus.Mem_Addr];
        end
    end

    assign bus.Mem_Rdata = ram_q;

    // Reference model: log of accepted accesses by cycle, and the memory contents they imply
    typedef struct {
        bit                v;
        bit                we;
        int                who;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
    } acc_t;

    acc_t              acc_log [int];
    logic [DATA_W-1:0] mdl_mem [0:MEM_SZ-1];
    logic [DATA_W-1:0] last_rd;
    bit                favour_ply;
    int                vectors     = 0;
    int                miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic acc_t empty_acc();
        acc_t a;
        a.v = 1'b0; a.we = 1'b0; a.who = W_NONE;
        a.addr = '0; a.wdata = '0; a.rdata = '0;
        return a;
    endfunction

    function automatic acc_t get_acc(input int n);
        if (acc_log.exists(n)) return acc_log[n];
        return empty_acc();
    endfunction

    initial begin
        for (int i = 0; i < MEM_SZ; i++) begin
            ram[i]     = '0;
            mdl_mem[i] = '0;
        end
        ram[17'h00010]     = 16'hBEEF;
        mdl_mem[17'h00010] = 16'hBEEF;
    end

    // Compare process: every falling edge, the DUT must match what the access log implies
    initial begin : compare
        int   cyc;
        int   who;
        acc_t a1, a2, g;
        bit   exp_prv, exp_srv;
        cyc        = 0;
        favour_ply = 1'b1;
        last_rd    = '0;
        forever begin
            @(negedge Clk);
            cyc++;
            a1 = get_acc(cyc - 1);
            a2 = get_acc(cyc - 2);
            g  = empty_acc();
            if (!Reset) begin
                acc_log.delete(cyc - 1);
                favour_ply = 1'b1;
                last_rd    = '0;
                chk("rst_rec_gnt", bus.Rec_Gnt, 0);
                chk("rst_ply_gnt", bus.Ply_Gnt, 0);
                chk("rst_shf_gnt", bus.Shf_Gnt, 0);
                chk("rst_mem_en", bus.Mem_En, 0);
                chk("rst_mem_we", bus.Mem_We, 0);
                chk("rst_mem_addr", bus.Mem_Addr, 0);
                chk("rst_mem_wdata", bus.Mem_Wdata, 0);
                chk("rst_ply_rvalid", bus.Ply_Rvalid, 0);
                chk("rst_shf_rvalid", bus.Shf_Rvalid, 0);
                chk("rst_rd_data", bus.Rd_Data, 0);
                chk("rst_busy", bus.Busy, 0);
            end else begin
                // The access granted last cycle reaches the RAM now
                if (a1.v) begin
                    if (a1.we) mdl_mem[a1.addr] = a1.wdata;
                    else begin
                        a1.rdata = mdl_mem[a1.addr];
                        acc_log[cyc - 1] = a1;
                    end
                end
                if (bus.Rec_Req)                     who = W_REC;
                else if (bus.Ply_Req && bus.Shf_Req) who = favour_ply ? W_PLY : W_SHF;
                else if (bus.Ply_Req)                who = W_PLY;
                else if (bus.Shf_Req)                who = W_SHF;
                else                                 who = W_NONE;
`ifdef ARB_ROUND_ROBIN_EN
                if (who == W_PLY || who == W_SHF) favour_ply = (who == W_SHF);
`endif
                exp_prv = a2.v && !a2.we && a2.who == W_PLY;
                exp_srv = a2.v && !a2.we && a2.who == W_SHF;
                if (exp_prv || exp_srv) last_rd = a2.rdata;

                chk("rec_gnt", bus.Rec_Gnt, who == W_REC);
                chk("ply_gnt", bus.Ply_Gnt, who == W_PLY);
                chk("shf_gnt", bus.Shf_Gnt, who == W_SHF);
                chk("mem_en", bus.Mem_En, a1.v);
                chk("mem_we", bus.Mem_We, a1.v && a1.we);
                if (a1.v) chk("mem_addr", bus.Mem_Addr, a1.addr);
                if (a1.v && a1.we) chk("mem_wdata", bus.Mem_Wdata, a1.wdata);
                chk("ply_rvalid", bus.Ply_Rvalid, exp_prv);
                chk("shf_rvalid", bus.Shf_Rvalid, exp_srv);
                chk("rd_data", bus.Rd_Data, last_rd);
                chk("busy", bus.Busy, a1.v || (a2.v && !a2.we));

                g.v   = (who != W_NONE);
                g.who = who;
                case (who)
                    W_REC: begin g.we = 1'b1; g.addr = bus.Rec_Addr; g.wdata = bus.Rec_Wdata; end
                    W_PLY: begin g.we = 1'b0; g.addr = bus.Ply_Addr; end
                    W_SHF: begin g.we = bus.Shf_We; g.addr = bus.Shf_Addr; g.wdata = bus.Shf_Wdata; end
                    default: ;
                endcase
            end
            acc_log[cyc] = g;
            acc_log.delete(cyc - 3);
        end
    end

    task automatic idle();
        bus.Rec_Req = 1'b0;
        bus.Ply_Req = 1'b0;
        bus.Shf_Req = 1'b0;
        bus.Shf_We  = 1'b0;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        if ($urandom_range(0, 3) != 0) return ADDR_W'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 0) return 17'h1FFFF;
        return ADDR_W'($urandom);
    endfunction

    // Stimulus: directed scenarios with literal expectations, then random traffic
    initial begin : stim
        int code;
        int exp_code;
        idle();
        bus.Rec_Addr = '0; bus.Rec_Wdata = '0;
        bus.Ply_Addr = '0;
        bus.Shf_Addr = '0; bus.Shf_Wdata = '0;
        #1 Reset = 1'b0;
        repeat (3) @(posedge Clk);
        #1;

        // Contended player/shifter straight out of reset
        Reset = 1'b1;
        bus.Ply_Req = 1'b1; bus.Ply_Addr = 17'h00020;
        bus.Shf_Req = 1'b1; bus.Shf_We = 1'b0; bus.Shf_Addr = 17'h00030;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            code = bus.Ply_Gnt ? 1 : (bus.Shf_Gnt ? 2 : 0);
`ifdef ARB_ROUND_ROBIN_EN
            exp_code = (i % 2 == 0) ? 1 : 2;
`else
            exp_code = 1;
`endif
            chk($sformatf("contend_grant%0d", i), code, exp_code);
            step();
        end
        idle();
        step(); step();

        // All three request together
        bus.Rec_Req = 1'b1; bus.Rec_Addr = 17'h0ABCD; bus.Rec_Wdata = 16'h5A5A;
        bus.Ply_Req = 1'b1; bus.Ply_Addr = 17'h00010;
        bus.Shf_Req = 1'b1; bus.Shf_We = 1'b1; bus.Shf_Addr = 17'h00011; bus.Shf_Wdata = 16'h1111;
        @(negedge Clk);
        chk("all3_rec_gnt", bus.Rec_Gnt, 1);
        chk("all3_ply_gnt", bus.Ply_Gnt, 0);
        chk("all3_shf_gnt", bus.Shf_Gnt, 0);
        step();
        idle();
        @(negedge Clk);
        chk("all3_mem_we", bus.Mem_We, 1);
        chk("all3_mem_addr", bus.Mem_Addr, 17'h0ABCD);
        chk("all3_mem_wdata", bus.Mem_Wdata, 16'h5A5A);
        step(); step(); step();

        // Player read of the preloaded word
        bus.Ply_Req = 1'b1; bus.Ply_Addr = 17'h00010;
        @(negedge Clk);
        chk("beef_ply_gnt", bus.Ply_Gnt, 1);
        step();
        idle();
        @(negedge Clk);
        chk("beef_early_rvalid", bus.Ply_Rvalid, 0);
        step();
        @(negedge Clk);
        chk("beef_ply_rvalid", bus.Ply_Rvalid, 1);
        chk("beef_rd_data", bus.Rd_Data, 16'hBEEF);
        chk("beef_shf_rvalid", bus.Shf_Rvalid, 0);
        step();
        @(negedge Clk);
        chk("beef_rvalid_pulse", bus.Ply_Rvalid, 0);
        chk("beef_rd_hold", bus.Rd_Data, 16'hBEEF);
        step();

        // Shifter write then immediate player read of the top address
        bus.Shf_Req = 1'b1; bus.Shf_We = 1'b1; bus.Shf_Addr = 17'h1FFFF; bus.Shf_Wdata = 16'h1234;
        @(negedge Clk);
        chk("raw_shf_gnt", bus.Shf_Gnt, 1);
        step();
        idle();
        bus.Ply_Req = 1'b1; bus.Ply_Addr = 17'h1FFFF;
        @(negedge Clk);
        chk("raw_ply_gnt", bus.Ply_Gnt, 1);
        chk("raw_no_shf_rvalid", bus.Shf_Rvalid, 0);
        step();
        idle();
        @(negedge Clk);
        step();
        @(negedge Clk);
        chk("raw_ply_rvalid", bus.Ply_Rvalid, 1);
        chk("raw_rd_data", bus.Rd_Data, 16'h1234);
        step(); step();

        // Reset one cycle after a player grant discards the read
        bus.Ply_Req = 1'b1; bus.Ply_Addr = 17'h00010;
        @(negedge Clk);
        chk("rstmid_ply_gnt", bus.Ply_Gnt, 1);
        step();
        idle();
        Reset = 1'b0;
        @(negedge Clk);
        chk("rstmid_mem_en", bus.Mem_En, 0);
        chk("rstmid_busy", bus.Busy, 0);
        step();
        Reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            chk($sformatf("rstmid_no_rvalid%0d", i), bus.Ply_Rvalid, 0);
            step();
        end

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if (!Reset)                            Reset = 1'b1;
            else if ($urandom_range(0, 299) == 0)  Reset = 1'b0;
            bus.Rec_Req   = ($urandom_range(0, 3) == 0);
            bus.Rec_Addr  = rand_addr();
            bus.Rec_Wdata = DATA_W'($urandom);
            bus.Ply_Req   = ($urandom_range(0, 1) == 0);
            bus.Ply_Addr  = rand_addr();
            bus.Shf_Req   = ($urandom_range(0, 1) == 0);
            bus.Shf_We    = ($urandom_range(0, 1) == 0);
            bus.Shf_Addr  = rand_addr();
            bus.Shf_Wdata = DATA_W'($urandom);
            step();
        end
        Reset = 1'b1;
        idle();
        repeat (4) step();
        @(negedge Clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/audio_mem_arbiter.md
AUDIO_MEM_ARBITER -- requirements
Module: audio_mem_arbiter

Interface
- REQ-001 Parameter: ADDR_W, 17, sample-memory address width.
- REQ-002 Parameter: DATA_W, 16, sample width.
- REQ-003 Clk  input  1  system clock; all logic on rising edge.
- REQ-004 Reset  input  1  asynchronous, active-low reset.
- REQ-005 Rec_Req  input  1  recorder write request.
- REQ-006 Rec_Addr/Rec_Wdata  input  ADDR_W/DATA_W  recorder write address/sample.
- REQ-007 Rec_Gnt  output  1  recorder request accepted this cycle.
- REQ-008 Ply_Req  input  1  player read request.
- REQ-009 Ply_Addr  input  ADDR_W  player read address.
- REQ-010 Ply_Gnt/Ply_Rvalid  output  1/1  player accept / player read data valid.
- REQ-011 Shf_Req/Shf_We  input  1/1  shifter request / 1=write, 0=read.
- REQ-012 Shf_Addr/Shf_Wdata  input  ADDR_W/DATA_W  shifter address/write sample.
- REQ-013 Shf_Gnt/Shf_Rvalid  output  1/1  shifter accept / shifter read data valid.
- REQ-014 Rd_Data  output  DATA_W  shared read data, qualified by *_Rvalid.
- REQ-015 Mem_En/Mem_We  output  1/1  single-port synchronous RAM enable/write.
- REQ-016 Mem_Addr/Mem_Wdata  output  ADDR_W/DATA_W  RAM address/write data.
- REQ-017 Mem_Rdata  input  DATA_W  RAM read data, valid one cycle after a read Mem_En.
- REQ-018 Busy  output  1  any access in the pipeline.

Function
- REQ-019 At most one of Rec_Gnt, Ply_Gnt, Shf_Gnt SHALL be high per cycle; each grant is combinational from the current requests and arbiter state.
- REQ-020 A grant SHALL be given only to an active request; with no request, all grants SHALL be 0.
- REQ-021 Rec_Req SHALL have strict highest priority; recorder writes are never delayed by the other requesters.
- REQ-022 Without round-robin, priority SHALL be Rec > Ply > Shf.
- REQ-023 A request is consumed on the cycle its grant is high; a requester holding Req high after a grant issues a new access.
- REQ-024 Stage 1 (cycle after grant) SHALL drive Mem_En=1, Mem_We, Mem_Addr, Mem_Wdata from the granted requester's registered inputs; otherwise Mem_En=0 and Mem_We=0.
- REQ-025 Each stage-1 read SHALL carry a 2-bit owner tag (Ply or Shf) into stage 2.
- REQ-026 Stage 2 SHALL register Mem_Rdata onto Rd_Data and pulse exactly one of Ply_Rvalid/Shf_Rvalid per the tag for one cycle; read latency from grant to Rvalid is 2 cycles.
- REQ-027 Writes (recorder, or shifter with Shf_We=1) SHALL produce no Rvalid.
- REQ-028 Rd_Data SHALL hold its last value when no Rvalid is asserted.
- REQ-029 Back-to-back grants SHALL be accepted every cycle; throughput is one access per cycle with no bubbles.
- REQ-030 Busy SHALL be 1 while stage 1 or stage 2 holds an access.
- REQ-031 A write followed next cycle by a read of the same address SHALL return the new data (RAM write-first ordering relies on serialised single port).

Reset
- REQ-032 On Reset low, all grants, Mem_En, Mem_We, Ply_Rvalid, Shf_Rvalid, and Busy SHALL be 0; Mem_Addr, Mem_Wdata, and Rd_Data SHALL be 0; tags cleared; round-robin pointer SHALL favour Ply.
- REQ-033 Reset asserted mid-operation SHALL discard in-flight accesses; no Rvalid for them follows reset release.
- REQ-034 The first grant SHALL be possible in the first cycle after Reset deasserts.

Configuration
- REQ-035 Macro ARB_ROUND_ROBIN_EN: when defined, Ply and Shf SHALL alternate on simultaneous requests; the pointer toggles after each Ply or Shf grant. Rec remains strict priority.
- REQ-036 When ARB_ROUND_ROBIN_EN is undefined, fixed priority per REQ-022 applies and no pointer register is present.

Verification
- REQ-037 Rec, Ply, and Shf requesting in the same cycle: Rec_Gnt=1 only; Mem_We=1 with Rec_Addr next cycle.
- REQ-038 Ply read at address 0x00010 holding 0xBEEF: Ply_Rvalid pulses 2 cycles after Ply_Gnt with Rd_Data=0xBEEF; Shf_Rvalid stays 0.
- REQ-039 Ply and Shf held high 6 cycles: with the macro, grants are P,S,P,S,P,S; without it, all six grants go to Ply.
- REQ-040 Shf write of 0x1234 to 0x1FFFF, then Ply read of 0x1FFFF: Ply_Rvalid carries 0x1234.
- REQ-041 Reset pulsed low one cycle after Ply_Gnt: Ply_Rvalid never asserts; all outputs are 0 during reset.
